mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 multiplexed output channel between two requesters.
- Sequences the mux select from a round-robin arbiter with bounded-burst grants.
- Presents the selected requester's data on a valid/ready output channel.
- Sits between two producer blocks and a single downstream consumer, and owns the mux select line.

Parameters:
- WIDTH, 8, data width of d0, d1 and y.
- MAX_BURST, 4, maximum transfers per grant before re-arbitration (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req0  input  1  requester 0 has data; held high with d0 stable until its transfers finish
- d0  input  WIDTH  requester 0 data
- req1  input  1  requester 1 has data; held high with d1 stable until its transfers finish
- d1  input  WIDTH  requester 1 data
- gnt0  output  1  requester 0 owns the channel (registered)
- gnt1  output  1  requester 1 owns the channel (registered)
- s  output  1  mux select: 0 = d0, 1 = d1 (registered)
- y  output  WIDTH  channel data, equal to (d0 & ~s) | (d1 & s) bitwise
- y_valid  output  1  channel data valid
- y_ready  input  1  consumer accepts y this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high; the state clears immediately on rst assertion, without waiting for a clock edge.
- Reset values: state IDLE; gnt0 = 0, gnt1 = 0, s = 0; y_valid = 0; burst counter = 0; last = 1, so requester 0 wins the first contention.
- States: IDLE, GRANT0, GRANT1. gnt0 = (state == GRANT0) and gnt1 = (state == GRANT1); both are registered and never high together.
- y is combinational from the registered s: the mux path only.
- y_valid = (GRANT0 & req0) | (GRANT1 & req1). It is low in IDLE.
- A transfer occurs on a clock edge where y_valid & y_ready = 1.
- IDLE:
  - Neither request: stay in IDLE.
  - Only reqN: go to GRANTN.
  - Both requests: grant the requester not equal to last.
  - On entry to GRANTN: s <= N and counter <= 0.
  - Latency: request seen in IDLE -> grant high on the next cycle -> first possible transfer in that cycle.
- GRANTN:
  - On each transfer, the counter increments.
  - If reqN is low, go to IDLE. No transfer happens that cycle because y_valid = 0.
  - On a transfer with counter == MAX_BURST-1, go to IDLE even if reqN stays high.
  - Otherwise stay in GRANTN; s holds and the burst continues.
  - On every exit from GRANTN: last <= N; s holds its value in IDLE.
- Throughput: up to MAX_BURST transfers back-to-back per grant, then one IDLE bubble cycle.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1,... and each grant carries MAX_BURST transfers.
- Backpressure: y_ready low stalls the burst. State, s and counter hold; y follows dN.
- Requester rule: a requester drops reqN after observing its last intended transfer (gntN & y_ready at a clock edge). If reqN drops mid-burst, the grant releases the next cycle.
- Reset mid-burst: the burst is abandoned; outputs take reset values asynchronously. After reset release, arbitration restarts with requester 0 favoured.
- MAX_BURST = 1: exactly one transfer per grant, then IDLE.
- Counter width: $clog2(MAX_BURST) + 1 bits. The counter never exceeds MAX_BURST-1.
- Simultaneous reqN drop and y_ready high: no transfer; go to IDLE.

Test Plan:
- Reset: assert rst mid-cycle with req0 = 1 in GRANT0 -> gnt0, gnt1, s, y_valid go to 0 immediately. After release, req0 = req1 = 1 -> gnt0 high one cycle later.
- Single requester: req0 = 1, d0 = 8'hA5, y_ready = 1, MAX_BURST = 4 -> 4 transfers of y = A5, one IDLE cycle, then GRANT0 again.
- Contention: req0 = req1 = 1 held, d0 = 8'h11, d1 = 8'h22, y_ready = 1 -> y sequence 11×4, bubble, 22×4, bubble, 11×4; s toggles 0/1.
- Backpressure: GRANT1 with y_ready low for 5 cycles -> gnt1 and s = 1 hold, counter unchanged, no transfers; resume -> remaining transfers complete.
- Early release: req1 drops after 2 transfers while req0 = 1 -> IDLE next cycle, then GRANT0; last = 1.
- MAX_BURST = 1, both requesting -> grants alternate every 2 cycles; exactly one transfer per grant.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux select.
// Each grant carries at most MAX_BURST transfers on a valid/ready channel.
module mux2_rr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] d0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             s,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   // One-hot grant encoding so each grant output is a flop bit directly.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic             s_q, s_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             xfer;
   logic             burst_done;

   assign gnt0       = state_q[0];
   assign gnt1       = state_q[1];
   assign s          = s_q;
   assign y          = (d0 & ~{WIDTH{s_q}}) | (d1 & {WIDTH{s_q}});
   assign y_valid    = (state_q[0] & req0) | (state_q[1] & req1);
   assign xfer       = y_valid & y_ready;
   assign burst_done = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            // On contention, last_q == 1 means requester 0 is owed the grant.
            if (req0 && (!req1 || last_q)) begin
               state_d = GRANT0;
               s_d     = 1'b0;
               cnt_d   = '0;
            end else if (req1) begin
               state_d = GRANT1;
               s_d     = 1'b1;
               cnt_d   = '0;
            end
         end
         GRANT0: begin
            if (!req0) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end else if (xfer) begin
               if (burst_done) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         GRANT1: begin
            if (!req1) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end else if (xfer) begin
               if (burst_done) begin
                  state_d = IDLE;
                  last_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: MAX_BURST=4 main instance plus a
// MAX_BURST=1 instance sharing the same stimulus.
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, y_ready;
   logic [7:0] d0, d1;
   logic       gnt0, gnt1, s, y_valid;
   logic [7:0] y;
   logic       gnt0_b, gnt1_b, s_b, y_valid_b;
   logic [7:0] y_b;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
      .clk(clk), .rst(rst), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .s(s), .y(y), .y_valid(y_valid), .y_ready(y_ready)
   );

   mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut_b1 (
      .clk(clk), .rst(rst), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .y(y_b), .y_valid(y_valid_b),
      .y_ready(y_ready)
   );

   task automatic do_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; y_ready = 1'b0; d0 = '0; d1 = '0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; y_ready = 1'b0; d0 = 8'h5C; d1 = 8'hC5;
      @(negedge clk); #1;
      n_checks++;
      if ({gnt1, gnt0, s, y_valid} !== 4'b0000)
         $display("FAIL reset_values: got %b expected 0000", {gnt1, gnt0, s, y_valid});
      else n_pass++;
      @(negedge clk);
      rst  = 1'b0;
      req1 = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({gnt1, gnt0, s} !== 3'b101)
         $display("FAIL reset_pre_grant1: got %b expected 101", {gnt1, gnt0, s});
      else n_pass++;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({gnt1, gnt0, s, y_valid} !== 4'b0000)
         $display("FAIL reset_async: got %b expected 0000", {gnt1, gnt0, s, y_valid});
      else n_pass++;
      @(negedge clk);
      rst  = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      #1;
      n_checks++;
      if ({gnt1, gnt0} !== 2'b00)
         $display("FAIL reset_release_idle: got %b expected 00", {gnt1, gnt0});
      else n_pass++;
      @(negedge clk); #1;
      n_checks++;
      if ({gnt1, gnt0, s, y_valid, y} !== {4'b0101, 8'h5C})
         $display("FAIL reset_first_win: got %b/%h expected 0101/5c",
                  {gnt1, gnt0, s, y_valid}, y);
      else n_pass++;
   endtask

   task automatic test_single();
      int exp_st[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 8; i++) exp_q.push_back(8'hA5);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req0 = 1'b1; d0 = 8'hA5; y_ready = 1'b1;
         #1;
         n_checks++;
         if ({gnt1, gnt0} !== 2'(exp_st[c]))
            $display("FAIL single_state c%0d: got %b expected %b", c, {gnt1, gnt0}, 2'(exp_st[c]));
         else n_pass++;
         if (y_valid && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL single_extra_xfer c%0d: got %h expected none", c, y);
            else if (y !== exp_q[0]) begin
               $display("FAIL single_y c%0d: got %h expected %h", c, y, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               n_pass++;
               void'(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL single_missing: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_contention();
      int   exp_st[15] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1};
      logic exp_s = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h11);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h22);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h11);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
         #1;
         if (exp_st[c] == 1) exp_s = 1'b0;
         if (exp_st[c] == 2) exp_s = 1'b1;
         n_checks++;
         if ({gnt1, gnt0, s} !== {2'(exp_st[c]), exp_s})
            $display("FAIL contention_state c%0d: got %b expected %b", c,
                     {gnt1, gnt0, s}, {2'(exp_st[c]), exp_s});
         else n_pass++;
         if (y_valid && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL contention_extra_xfer c%0d: got %h expected none", c, y);
            else if (y !== exp_q[0]) begin
               $display("FAIL contention_y c%0d: got %h expected %h", c, y, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               n_pass++;
               void'(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL contention_missing: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int   exp_st[11] = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
      logic rdy[11]    = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h3C);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         req1 = 1'b1; d1 = 8'h3C; d0 = 8'hF0; y_ready = rdy[c];
         #1;
         n_checks++;
         if ({gnt1, gnt0} !== 2'(exp_st[c]))
            $display("FAIL bp_state c%0d: got %b expected %b", c, {gnt1, gnt0}, 2'(exp_st[c]));
         else n_pass++;
         if (!rdy[c]) begin
            n_checks++;
            if ({s, y_valid, y} !== {2'b11, 8'h3C})
               $display("FAIL bp_hold c%0d: got %b/%h expected 11/3c", c, {s, y_valid}, y);
            else n_pass++;
         end
         if (y_valid && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL bp_extra_xfer c%0d: got %h expected none", c, y);
            else if (y !== exp_q[0]) begin
               $display("FAIL bp_y c%0d: got %h expected %h", c, y, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               n_pass++;
               void'(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL bp_missing: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_early_release();
      int   exp_st[6] = '{0, 2, 2, 2, 0, 1};
      logic r0[6]     = '{0, 0, 0, 1, 1, 1};
      logic r1[6]     = '{1, 1, 1, 0, 1, 1};
      logic exp_v[6]  = '{0, 1, 1, 0, 0, 1};
      do_reset();
      exp_q.push_back(8'h88);
      exp_q.push_back(8'h88);
      exp_q.push_back(8'h77);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req0 = r0[c]; req1 = r1[c]; d0 = 8'h77; d1 = 8'h88; y_ready = 1'b1;
         #1;
         n_checks++;
         if ({gnt1, gnt0, y_valid} !== {2'(exp_st[c]), exp_v[c]})
            $display("FAIL early_state c%0d: got %b expected %b", c,
                     {gnt1, gnt0, y_valid}, {2'(exp_st[c]), exp_v[c]});
         else n_pass++;
         if (y_valid && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL early_extra_xfer c%0d: got %h expected none", c, y);
            else if (y !== exp_q[0]) begin
               $display("FAIL early_y c%0d: got %h expected %h", c, y, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               n_pass++;
               void'(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL early_missing: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_burst1();
      int exp_st[9] = '{0, 1, 0, 2, 0, 1, 0, 2, 0};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(8'h11);
         exp_q.push_back(8'h22);
      end
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22; y_ready = 1'b1;
         #1;
         n_checks++;
         if ({gnt1_b, gnt0_b} !== 2'(exp_st[c]))
            $display("FAIL burst1_state c%0d: got %b expected %b", c,
                     {gnt1_b, gnt0_b}, 2'(exp_st[c]));
         else n_pass++;
         if (y_valid_b && y_ready) begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL burst1_extra_xfer c%0d: got %h expected none", c, y_b);
            else if (y_b !== exp_q[0]) begin
               $display("FAIL burst1_y c%0d: got %h expected %h", c, y_b, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               n_pass++;
               void'(exp_q.pop_front());
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL burst1_missing: got %0d left expected 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_early_release();
      test_burst1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
